// File: rtl/mult_cpa_stage.sv
// -----------------------------------------------------------------------------
// mult_cpa_stage
//   Final carry-propagate adder for the integer multiplier. It takes the
//   redundant sum/carry pair from the last 3:2 compressor and resolves it into
//   a 64-bit product in two pipeline stages. It then returns either the low or
//   the high 32-bit word of that product.
//     S1 : adds the low halves and keeps the carry out of bit 31 (c32). It also
//          holds the unresolved high halves, the word select and the tag.
//     S2 : adds the high halves together with c32. It then registers the
//          selected word. S2 is the output register.
//   The bench-visible handshake is valid/ready on both sides. flush kills both
//   stages. rst is synchronous, active-high, and has priority over everything.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   flush      in   discard every in-flight operation
//   in_valid   in   sum/carry pair presented
//   in_ready   out  stage accepts an input this cycle (combinational)
//   in_sum     in   [63:0] redundant sum vector
//   in_carry   in   [63:0] redundant carry vector, aligned with in_sum
//   in_hi      in   0 = return product[31:0], 1 = return product[63:32]
//   in_tag     in   [TAG_W-1:0] destination tag, passed through
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   out_result out  [31:0] selected product word
//   out_tag    out  [TAG_W-1:0] tag of the result
//   busy       out  any stage holds a valid operation
// -----------------------------------------------------------------------------
module mult_cpa_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_sum,
  input  logic [63:0]      in_carry,
  input  logic             in_hi,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // S1 state
  logic             s1_valid_q,   s1_valid_d;
  logic [31:0]      s1_lo_q,      s1_lo_d;
  logic             s1_c32_q,     s1_c32_d;
  logic [31:0]      s1_sum_hi_q,  s1_sum_hi_d;
  logic [31:0]      s1_carry_hi_q, s1_carry_hi_d;
  logic             s1_hi_q,      s1_hi_d;
  logic [TAG_W-1:0] s1_tag_q,     s1_tag_d;

  // S2 (output register) state
  logic             out_valid_q,  out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q,    out_tag_d;

  // Handshake and datapath helpers
  logic             adv2_s;
  logic             in_xfer_s;
  logic             s1_to_s2_s;
  logic [32:0]      lo_add_s;
  logic [31:0]      hi_add_s;

  // Handshake decode. S2 can take new data when it is empty or being drained.
  // in_ready does not look at in_valid, so no combinational loop can form upstream.
  always_comb begin
    adv2_s     = ~out_valid_q | out_ready;
    in_ready   = ~flush & (~s1_valid_q | adv2_s);
    in_xfer_s  = in_valid & in_ready;
    s1_to_s2_s = s1_valid_q & adv2_s;
  end

  // Split carry-propagate add. The low half is added on entry to S1. The high
  // half is completed on entry to S2 using the registered c32. Any carry out
  // of bit 63 falls off the 32-bit high-half adder.
  always_comb begin
    lo_add_s = {1'b0, in_sum[31:0]} + {1'b0, in_carry[31:0]};
    hi_add_s = s1_sum_hi_q + s1_carry_hi_q + {31'd0, s1_c32_q};
  end

  // Next-state for both stages. flush clears both valid bits and blocks every
  // transfer. Data registers only move on a transfer, so the output word stays
  // frozen while it waits for out_ready.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_lo_d       = s1_lo_q;
    s1_c32_d      = s1_c32_q;
    s1_sum_hi_d   = s1_sum_hi_q;
    s1_carry_hi_d = s1_carry_hi_q;
    s1_hi_d       = s1_hi_q;
    s1_tag_d      = s1_tag_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_tag_d     = out_tag_q;

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      // S1: reload on input transfer, even when it drains in the same cycle.
      if (in_xfer_s) begin
        s1_valid_d    = 1'b1;
        s1_lo_d       = lo_add_s[31:0];
        s1_c32_d      = lo_add_s[32];
        s1_sum_hi_d   = in_sum[63:32];
        s1_carry_hi_d = in_carry[63:32];
        s1_hi_d       = in_hi;
        s1_tag_d      = in_tag;
      end else if (s1_to_s2_s) begin
        s1_valid_d = 1'b0;
      end else begin
        s1_valid_d = s1_valid_q;
      end

      // S2: a drain from S1 keeps out_valid high across an output transfer.
      if (s1_to_s2_s) begin
        out_valid_d  = 1'b1;
        out_result_d = s1_hi_q ? hi_add_s : s1_lo_q;
        out_tag_d    = s1_tag_q;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_lo_q       <= 32'd0;
      s1_c32_q      <= 1'b0;
      s1_sum_hi_q   <= 32'd0;
      s1_carry_hi_q <= 32'd0;
      s1_hi_q       <= 1'b0;
      s1_tag_q      <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= 32'd0;
      out_tag_q     <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_lo_q       <= s1_lo_d;
      s1_c32_q      <= s1_c32_d;
      s1_sum_hi_q   <= s1_sum_hi_d;
      s1_carry_hi_q <= s1_carry_hi_d;
      s1_hi_q       <= s1_hi_d;
      s1_tag_q      <= s1_tag_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_tag_q     <= out_tag_d;
    end
  end

  // Output drive from the registers.
  always_comb begin
    out_valid  = out_valid_q;
    out_result = out_result_q;
    out_tag    = out_tag_q;
    busy       = s1_valid_q | out_valid_q;
  end

endmodule

// File: tb/tb_mult_cpa_stage.sv
module tb_mult_cpa_stage;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, in_hi;
  logic [63:0]      in_sum, in_carry;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, busy;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  mult_cpa_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_hi(in_hi), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference: full 64-bit wrap-around sum, then pick a word.
  function automatic logic [31:0] ref_res(logic [63:0] s, logic [63:0] c, logic h);
    logic [63:0] p;
    p = s + c;
    return h ? p[63:32] : p[31:0];
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Scoreboard push: record the expected response of every accepted input.
  always @(negedge clk) begin
    if (rst || flush) exp_q.delete();
    else if (in_valid && in_ready)
      exp_q.push_back('{res: ref_res(in_sum, in_carry, in_hi), tag: in_tag});
  end

  // Monitor: compare every output transfer against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", {32'd0, out_result}, 64'hDEAD_0000_DEAD);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", {32'd0, out_result}, {32'd0, e.res});
        chk("sb_tag", {59'd0, out_tag}, {59'd0, e.tag});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [63:0] s, logic [63:0] c, logic h, logic [TAG_W-1:0] t);
    in_valid = v; in_sum = s; in_carry = c; in_hi = h; in_tag = t;
  endtask

  task automatic rand_op(logic [TAG_W-1:0] t);
    drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), t);
  endtask

  // One isolated op: nothing after one edge, result after the second edge.
  task automatic one_op(string nm, logic [63:0] s, logic [63:0] c, logic h,
                        logic [TAG_W-1:0] t, logic [31:0] expv);
    out_ready = 1'b1;
    drive(1'b1, s, c, h, t);
    chk({nm, "_rdy"}, {63'd0, in_ready}, 64'd1);
    tick;
    drive(1'b0, 64'd0, 64'd0, 1'b0, '0);
    chk({nm, "_lat1_valid"}, {63'd0, out_valid}, 64'd0);
    chk({nm, "_lat1_busy"}, {63'd0, busy}, 64'd1);
    tick;
    chk({nm, "_lat2_valid"}, {63'd0, out_valid}, 64'd1);
    chk({nm, "_result"}, {32'd0, out_result}, {32'd0, expv});
    chk({nm, "_tag"}, {59'd0, out_tag}, {59'd0, t});
    tick;
    chk({nm, "_drained"}, {63'd0, out_valid}, 64'd0);
  endtask

  // Stall output and push inputs until S1 and S2 are both full.
  task automatic fill_both;
    out_ready = 1'b0;
    rand_op(5'd7);  tick;
    rand_op(5'd8);  tick;
    rand_op(5'd9);
  endtask

  initial begin
    logic [31:0] held;
    int          acc;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 1'b0, '0);
    tick; tick;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_result", {32'd0, out_result}, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Carry propagation corner cases.
    one_op("c32_hi", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1, 5'd3, 32'h0000_0001);
    one_op("c32_lo", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 5'd4, 32'h0000_0000);
    one_op("c64_drop", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 5'd5, 32'h0000_0000);
    one_op("plain_lo", 64'h1234_5678_0000_0010, 64'h0000_0001_0000_0020, 1'b0, 5'd6, 32'h0000_0030);

    // Back-to-back: four results on consecutive cycles, in order.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        rand_op(5'(i + 1));
        chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
      end else begin
        drive(1'b0, 64'd0, 64'd0, 1'b0, '0);
      end
      tick;
      if (i >= 1 && i <= 4) begin
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_tag", {59'd0, out_tag}, 64'(i));
      end
    end
    chk("b2b_idle", {63'd0, busy}, 64'd0);

    // Backpressure: only two accepted, result frozen, then both delivered.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      rand_op(5'(10 + i));
      chk("bp_in_ready", {63'd0, in_ready}, (i < 2) ? 64'd1 : 64'd0);
      if (in_ready) acc++;
      if (i == 3) chk("bp_hold", {32'd0, out_result}, {32'd0, held});
      tick;
      if (i == 1) held = out_result;
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_hold_end", {32'd0, out_result}, {32'd0, held});
    chk("bp_tag_head", {59'd0, out_tag}, 64'd10);
    drive(1'b0, 64'd0, 64'd0, 1'b0, '0);
    out_ready = 1'b1;
    tick;
    chk("bp_second_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_second_tag", {59'd0, out_tag}, 64'd11);
    tick;
    chk("bp_empty", {63'd0, busy}, 64'd0);

    // Flush with both stages full and an input pending.
    fill_both;
    chk("fl_full_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    chk("fl_in_ready", {63'd0, in_ready}, 64'd0);
    tick;
    flush = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 1'b0, '0);
    out_ready = 1'b1;
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_busy", {63'd0, busy}, 64'd0);
    tick; tick;
    chk("fl_no_result", {63'd0, out_valid}, 64'd0);

    // Reset mid-operation.
    fill_both;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 1'b0, '0);
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_result", {32'd0, out_result}, 64'd0);
    chk("mrst_tag", {59'd0, out_tag}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    one_op("post_rst", 64'h0000_0002_8000_0000, 64'h0000_0003_8000_0000, 1'b1, 5'd21, 32'h0000_0006);

    // Randomised traffic with occasional flush, checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) rand_op(5'($urandom));
      else drive(1'b0, 64'd0, 64'd0, 1'b0, '0);
      if ($urandom_range(0, 3) == 0)
        in_carry = {in_sum[63:32], ~in_sum[31:0]} ^ 64'h0000_0000_0000_0001;
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 49) == 0);
      tick;
    end
    flush = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 1'b0, '0);
    out_ready = 1'b1;
    tick; tick; tick;
    chk("final_idle", {63'd0, busy}, 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_cpa_stage.md
MULT_CPA_STAGE -- requirements
Module: mult_cpa_stage

Interface
REQ-001 Parameter: TAG_W, default 5, width of the destination tag carried alongside each operation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  kills all in-flight operations.
REQ-005 in_valid  input  1  upstream compressor tree presents a sum/carry pair.
REQ-006 in_ready  output  1  stage accepts input this cycle.
REQ-007 in_sum  input  64  redundant-form sum vector from the final 3:2 compressor.
REQ-008 in_carry  input  64  redundant-form carry vector, already bit-aligned with in_sum.
REQ-009 in_hi  input  1  0 = return product bits [31:0] (MUL); 1 = return bits [63:32] (MULH/MULHSU/MULHU).
REQ-010 in_tag  input  TAG_W  destination tag, passed through unchanged.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_result  output  32  selected 32-bit result word.
REQ-014 out_tag  output  TAG_W  tag of the result.
REQ-015 busy  output  1  high when any pipeline stage holds a valid operation.

Function
REQ-016 Product = (in_sum + in_carry) mod 2^64; the carry out of bit 63 is discarded.
REQ-017 Two-stage carry-propagate pipeline: stage S1 registers the low-half sum [31:0], the carry out of bit 31 (c32), the operand high halves, in_hi and in_tag; stage S2 (output register) computes high half = sum[63:32] + carry[63:32] + c32 and registers the selected word.
REQ-018 Transfer on input occurs when in_valid & in_ready; transfer on output occurs when out_valid & out_ready.
REQ-019 adv2 = !out_valid | out_ready; S1 moves into S2 when s1_valid & adv2.
REQ-020 in_ready = !flush & (!s1_valid | adv2), purely combinational, no dependency on in_valid.
REQ-021 Latency: input accepted at edge N produces out_valid at edge N+2 when out_ready has been high; sustained throughput of one result per cycle.
REQ-022 Backpressure: while out_valid & !out_ready, out_result/out_tag SHALL hold stable; S1 holds its contents; in_ready falls once S1 is occupied.
REQ-023 s1_valid clears when S1 drains into S2 without a same-cycle input transfer; simultaneous drain and input transfer reloads S1 with the new operation.
REQ-024 out_valid clears after an output transfer when S1 is empty; it remains high when S1 drains into S2 in that same cycle.
REQ-025 flush high: s1_valid and out_valid clear at that edge regardless of out_ready; the input presented that cycle is not accepted; flush overrides all simultaneous transfers.
REQ-026 Data registers load only on transfer; their content while the valid bit is low is don't-care, but out_result SHALL not change while out_valid is high and out_ready is low.
REQ-027 busy = s1_valid | out_valid.

Reset
REQ-028 On rst at a rising edge: s1_valid=0, out_valid=0, out_result=0, out_tag=0, busy=0; in_ready is 1 in the first cycle after rst deasserts.
REQ-029 rst mid-operation discards all in-flight operations; no result for them is ever presented.
REQ-030 rst has priority over flush and all transfers.

Verification
REQ-031 in_sum=0x0000_0000_FFFF_FFFF, in_carry=0x1, in_hi=1, out_ready=1 -> two edges later out_result=0x0000_0001 (c32 propagation); same with in_hi=0 -> 0x0000_0000.
REQ-032 in_sum=0xFFFF_FFFF_FFFF_FFFF, in_carry=0x1, in_hi=1 -> out_result=0x0000_0000 (bit-64 carry discarded); in_sum=0x1234_5678_0000_0010, in_carry=0x0000_0001_0000_0020, in_hi=0 -> 0x0000_0030.
REQ-033 Back-to-back four inputs with tags 1..4, out_ready=1 -> out_valid high on four consecutive cycles starting edge N+2, tags 1,2,3,4 in order, in_ready constantly 1.
REQ-034 out_ready=0 for 4 cycles while in_valid=1 -> exactly two accepted, in_ready=0 from the third cycle, out_result stable; out_ready=1 then delivers both in order with no loss or duplication.
REQ-035 flush asserted with S1 and S2 full and in_valid=1 -> next cycle out_valid=0, busy=0, no result for any of the three operations appears.
REQ-036 rst asserted for one cycle while out_valid=1 and S1 full -> all outputs at reset values next cycle; a new input after rst yields a correct result at N+2.
